// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT input framer and its sign-extension helper.
package fft_pkg;

  localparam int WIN      = 12;
  localparam int WOUT     = 22;
  localparam int N        = 16;
  localparam int CW       = 4;
  localparam int FRAC_IN  = 7;
  localparam int FRAC_OUT = 15;

  // Alignment of the binary point, and sign-guard bits above the input MSB.
  localparam int SHIFT = FRAC_OUT - FRAC_IN;
  localparam int GUARD = WOUT - WIN - SHIFT;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_PAD = 1'b1
  } state_t;

  typedef struct packed {
    logic [WOUT-1:0] re;
    logic [WOUT-1:0] im;
    logic            sof;
    logic            eof;
  } beat_t;

endpackage

// File: rtl/s_ext_12_22.sv
// Lossless widening of a (1,12,7) word to (1,22,15): sign guard bits on top,
// zero fraction bits below. Inverse of the output saturator.
module s_ext_12_22
  import fft_pkg::*;
(
  input  logic [WIN-1:0]  i_din,
  output logic [WOUT-1:0] o_dout
);

  assign o_dout = {{GUARD{i_din[WIN-1]}}, i_din, {SHIFT{1'b0}}};

endmodule

// File: rtl/s_ext_12_22_framer.sv
// Input framer: widens samples, groups them into N-point frames with sof/eof,
// and zero-pads frames cut short by in_last. Two-entry output FIFO.
module s_ext_12_22_framer
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIN-1:0]  in_re,
  input  logic [WIN-1:0]  in_im,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WOUT-1:0] out_re,
  output logic [WOUT-1:0] out_im,
  output logic            out_sof,
  output logic            out_eof,
  output logic            frame_err
);

  beat_t          r_head;
  beat_t          r_tail;
  logic [1:0]     r_cnt;
  logic [CW-1:0]  r_idx;
  state_t         r_state;
  logic           r_in_ready;
  logic           r_frame_err;

  logic [WOUT-1:0] w_re_ext;
  logic [WOUT-1:0] w_im_ext;
  logic            w_in_fire;
  logic            w_pad_fire;
  logic            w_push;
  logic            w_pop;
  logic            w_last_idx;
  logic            w_short;
  beat_t           w_beat;
  logic [1:0]      w_cnt_nxt;
  state_t          w_state_nxt;

  s_ext_12_22 u_ext_re (.i_din(in_re), .o_dout(w_re_ext));
  s_ext_12_22 u_ext_im (.i_din(in_im), .o_dout(w_im_ext));

  // r_in_ready is only ever high in ST_RUN, so no state qualifier is needed here.
  assign w_in_fire  = in_valid && r_in_ready;
  assign w_pad_fire = (r_state == ST_PAD) && (r_cnt < 2'd2);
  assign w_push     = w_in_fire || w_pad_fire;
  assign w_pop      = (r_cnt != 2'd0) && out_ready;
  assign w_last_idx = (r_idx == CW'(N - 1));
  assign w_short    = w_in_fire && in_last && !w_last_idx;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_beat     = '0;
    w_beat.sof = (r_idx == '0);
    w_beat.eof = w_last_idx;
    if (r_state == ST_RUN) begin
      w_beat.re = w_re_ext;
      w_beat.im = w_im_ext;
    end

    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 2'd1;
    else if (!w_push && w_pop) w_cnt_nxt = r_cnt - 2'd1;

    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_short) w_state_nxt = ST_PAD;
      ST_PAD:  if (w_pad_fire && w_last_idx) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the FIFO slots are
  // reset too so the outputs read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_cnt       <= 2'd0;
      r_idx       <= '0;
      r_state     <= ST_RUN;
      r_in_ready  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_cnt_nxt < 2'd2) && (w_state_nxt == ST_RUN);
      r_frame_err <= w_short;
      // N is a power of two, so the natural wrap of r_idx closes each frame.
      if (w_push) r_idx <= r_idx + CW'(1);

      if (w_pop) begin
        if (w_push && r_cnt == 2'd1) r_head <= w_beat;
        else                         r_head <= r_tail;
      end else if (w_push) begin
        if (r_cnt == 2'd0) r_head <= w_beat;
        else               r_tail <= w_beat;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_cnt != 2'd0);
  assign out_re    = r_head.re;
  assign out_im    = r_head.im;
  assign out_sof   = r_head.sof;
  assign out_eof   = r_head.eof;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_s_ext_12_22_framer.sv
// Self-checking bench: randomized stimulus, queue-based reference model of the
// framing rules, and an independent output monitor that pops and compares.
module tb_s_ext_12_22_framer;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_re;
  logic [11:0] in_im;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] out_re;
  logic [21:0] out_im;
  logic        out_sof;
  logic        out_eof;
  logic        frame_err;

  s_ext_12_22_framer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im),
    .out_sof(out_sof), .out_eof(out_eof),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [45:0] exp_q[$];
  int          pos     = 0;
  int          err_exp = 0;
  int          err_seen = 0;
  int          rdy_mode = 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference widening: the (1,12,7) value times 2^8, as a 22-bit two's complement word.
  function automatic logic [21:0] widen(input logic [11:0] v);
    int x;
    x = $signed(v);
    x = x * 256;
    return x[21:0];
  endfunction

  function automatic logic [45:0] mk(input logic [11:0] re, input logic [11:0] im, input int p);
    return {widen(re), widen(im), p == 0, p == N - 1};
  endfunction

  task automatic model_push(input logic [11:0] re, input logic [11:0] im, input logic last);
    exp_q.push_back(mk(re, im, pos));
    if (last && pos != N - 1) begin
      err_exp++;
      for (int p = pos + 1; p < N; p++) exp_q.push_back(mk(12'h000, 12'h000, p));
      pos = 0;
    end else begin
      pos = (pos + 1) % N;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting clock edge.
  task automatic send(input logic [11:0] re, input logic [11:0] im, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    in_last  = last;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=in_ready_low exp=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    model_push(re, im, last);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_rand(input logic last, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    send(12'($urandom), 12'($urandom), last);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor.
  logic [45:0] held;
  bit          held_v  = 1'b0;
  logic        prev_err = 1'b0;
  logic [45:0] cur;

  always @(negedge clk) begin
    cur = {out_re, out_im, out_sof, out_eof};
    if (!rst_n) begin
      held_v   = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (frame_err) begin
        err_seen++;
        check("frame_err_pulse_width", 64'(prev_err), 64'd0);
      end
      prev_err = frame_err;
      if (held_v) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(cur), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got=%h exp=none", cur);
        end else begin
          check("beat", 64'(cur), 64'(exp_q.pop_front()));
        end
        held_v = 1'b0;
      end else if (out_valid) begin
        held_v = 1'b1;
        held   = cur;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    int err_before;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset values.
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'({out_re, out_im, out_sof, out_eof}), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 check("in_ready_after_edge", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Streaming ramp with one-cycle latency.
    rdy_mode = 1;
    for (int k = 0; k < N; k++) begin
      send(12'(k), 12'(-k), 1'b0);
      check("latency_valid", 64'(out_valid), 64'd1);
      check("latency_re", 64'(out_re), 64'(widen(12'(k))));
    end

    // Full-scale extremes.
    send(12'h7FF, 12'h800, 1'b0);
    check("ext_pos_fs", 64'(out_re), 64'h07FF00);
    check("ext_neg_fs", 64'(out_im), 64'h380000);
    for (int k = 1; k < N; k++) send_rand(1'b0, 1'b0);

    // Short frame: last on beat 5, then pad; next frame starts fresh.
    for (int k = 0; k < 5; k++) send_rand(1'b0, 1'b0);
    send_rand(1'b1, 1'b0);
    check("short_in_ready_low", 64'(in_ready), 64'd0);
    for (int k = 0; k < N; k++) send_rand(1'b0, 1'b0);
    drain();
    check("short_err_count", 64'(err_seen), 64'(err_exp));

    // FIFO full: two buffered beats drop in_ready, head holds first beat.
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    send(12'h123, 12'h456, 1'b0);
    send(12'h9AB, 12'hCDE, 1'b0);
    check("full_in_ready_low", 64'(in_ready), 64'd0);
    check("full_head_re", 64'(out_re), 64'(widen(12'h123)));

    // Random back-pressure over three frames, with an occasional short frame.
    rdy_mode = 2;
    for (int k = 0; k < 3 * N; k++) send_rand(($urandom_range(0, 39) == 0), 1'b1);

    // Reset mid-frame after beat 7.
    rdy_mode = 1;
    n = 0;
    while (pos != 8 && n < 40) begin
      send_rand(1'b0, 1'b0);
      n++;
    end
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'({out_re, out_im, out_sof, out_eof}), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    pos = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(12'h321, 12'hFFF, 1'b0);
    check("post_rst_sof", 64'(out_sof), 64'd1);
    check("post_rst_re", 64'(out_re), 64'(widen(12'h321)));
    for (int k = 1; k < N; k++) send_rand(1'b0, 1'b0);

    // Five back-to-back frames with random stalls, no in_last.
    err_before = err_seen;
    rdy_mode = 2;
    for (int k = 0; k < 5 * N; k++) send_rand(1'b0, ($urandom_range(0, 3) == 0));
    rdy_mode = 1;
    drain();
    repeat (3) @(negedge clk);
    check("wrap_no_err", 64'(err_seen), 64'(err_before));
    check("final_err_count", 64'(err_seen), 64'(err_exp));
    check("final_idle", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
